// File: rtl/shift_rows_pipe.sv
// Registered AES ShiftRows / InvShiftRows for NB = 4/6/8 columns, behind a
// 2-entry valid/ready FIFO. Direction and tag are chosen per accepted block.
module shift_rows_pipe #(
    parameter int NB    = 4,
    parameter int TAG_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_inv,
    input  logic [TAG_W-1:0]    in_tag,
    input  logic [32*NB-1:0]    in_state,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [TAG_W-1:0]    out_tag,
    output logic [32*NB-1:0]    out_state,
    output logic [1:0]          occupancy
);
    localparam int          W    = 32 * NB;
    localparam int unsigned NCOL = NB;

    generate
        if (NB != 4 && NB != 6 && NB != 8) begin : g_bad_nb
            $error("shift_rows_pipe: NB must be 4, 6 or 8");
        end
    endgenerate

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } buf_state_t;

    buf_state_t         state;
    logic [W-1:0]       data_q [2];
    logic [TAG_W-1:0]   tag_q  [2];
    logic               rd_ptr;
    logic               wr_ptr;
    logic               push;
    logic               pop;
    logic [W-1:0]       shifted;

    // Row 2/3 offsets grow by one for the 256-bit block.
    function automatic int unsigned row_off(input int unsigned r);
        return (NCOL == 8 && r >= 2) ? r + 1 : r;
    endfunction

    function automatic logic [W-1:0] shift_state(input logic [W-1:0] s, input logic inv);
        logic [W-1:0] o;
        int unsigned  src;
        o = '0;
        for (int unsigned r = 0; r < 4; r++) begin
            for (int unsigned c = 0; c < NCOL; c++) begin
                src = inv ? (c + NCOL - row_off(r)) % NCOL : (c + row_off(r)) % NCOL;
                o[W-1-8*(r+4*c) -: 8] = s[W-1-8*(r+4*src) -: 8];
            end
        end
        return o;
    endfunction

    assign shifted   = shift_state(in_state, in_inv);
    assign in_ready  = !rst && (state != FULL);
    assign out_valid = (state != EMPTY);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_state = data_q[rd_ptr];
    assign out_tag   = tag_q[rd_ptr];
    assign occupancy = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= EMPTY;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            for (int unsigned i = 0; i < 2; i++) begin
                data_q[i] <= '0;
                tag_q[i]  <= '0;
            end
        end else begin
            if (push) begin
                data_q[wr_ptr] <= shifted;
                tag_q[wr_ptr]  <= in_tag;
                wr_ptr         <= !wr_ptr;
            end
            if (pop)
                rd_ptr <= !rd_ptr;
            unique case (state)
                EMPTY:   if (push) state <= ONE;
                ONE: begin
                    if (push && !pop)
                        state <= FULL;
                    else if (pop && !push)
                        state <= EMPTY;
                end
                FULL:    if (pop) state <= ONE;
                default: state <= EMPTY;
            endcase
        end
    end

endmodule
